noc_inject_arbiter: RTL and testbench

//  Wormhole packet arbiter that shares one NoC node local inject port between NUM_REQ traffic sources.

---
 rtl/noc_inject_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_arbiter.sv
// Wormhole inject arbiter: round-robin grant on header flits, locked until the tail,
// feeding a 1-entry output register slice toward a NoC node receive port.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = `Noc_Data_Width,
    localparam int GNT_W  = $clog2(NUM_REQ)
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_flit,
    input  logic [NUM_REQ-1:0]        req_is_header,
    input  logic [NUM_REQ-1:0]        req_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_flit,
    output logic                      out_is_header,
    output logic                      out_is_tail,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      busy,
    output logic [15:0]               pkt_count,
    output logic                      proto_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [GNT_W-1:0]     rr_ptr_r;
    logic [GNT_W-1:0]     grant_r;
    logic                 first_flit_r;
    logic                 out_valid_r;
    logic [DATA_W-1:0]    out_flit_r;
    logic                 out_hdr_r;
    logic                 out_tail_r;
    logic [15:0]          pkt_count_r;
    logic                 proto_err_r;

    logic [NUM_REQ-1:0]   cand_s;
    logic                 win_found_s;
    logic [GNT_W-1:0]     win_idx_s;
    logic [GNT_W-1:0]     scan_idx_s;
    logic                 slice_free_s;
    logic                 accept_s;
    logic [DATA_W-1:0]    sel_flit_s;
    logic                 sel_hdr_s;
    logic                 sel_tail_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic                 idle_err_s;
    logic                 hdr_err_s;

    assign cand_s       = req_valid & req_is_header;
    assign slice_free_s = !out_valid_r || out_ready;
    assign sel_flit_s   = req_flit[int'(grant_r)*DATA_W +: DATA_W];
    assign sel_hdr_s    = req_is_header[grant_r];
    assign sel_tail_s   = req_is_tail[grant_r];
    assign accept_s     = (state_r == ST_LOCKED) && req_valid[grant_r] && slice_free_s;
    assign idle_err_s   = (state_r == ST_IDLE) && (|(req_valid & ~req_is_header));
    assign hdr_err_s    = accept_s && sel_hdr_s && !first_flit_r;

    // Round-robin search: first header candidate strictly after the pointer, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {GNT_W{1'b0}};
        scan_idx_s  = {GNT_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx_s = GNT_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!win_found_s && cand_s[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Only the locked owner may be offered ready, and only when the slice can take a flit.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        if (state_r == ST_LOCKED) begin
            req_ready_s[grant_r] = slice_free_s;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && sel_tail_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant, round-robin pointer and first-flit tracking; pointer starts so req0 wins first.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            grant_r      <= {GNT_W{1'b0}};
            rr_ptr_r     <= GNT_W'(NUM_REQ - 1);
            first_flit_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && win_found_s) begin
            grant_r      <= win_idx_s;
            first_flit_r <= 1'b1;
        end else if (accept_s) begin
            first_flit_r <= sel_tail_s;
            if (sel_tail_s) begin
                rr_ptr_r <= grant_r;
            end
        end
    end

    // Output register slice: a same-cycle drain and load keeps the slice full.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            out_valid_r <= 1'b0;
            out_flit_r  <= {DATA_W{1'b0}};
            out_hdr_r   <= 1'b0;
            out_tail_r  <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_flit_r  <= sel_flit_s;
            out_hdr_r   <= sel_hdr_s;
            out_tail_r  <= sel_tail_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Delivered-packet counter (wraps) and sticky protocol error.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            pkt_count_r <= 16'h0000;
            proto_err_r <= 1'b0;
        end else begin
            if (out_valid_r && out_ready && out_tail_r) begin
                pkt_count_r <= pkt_count_r + 16'h0001;
            end
            if (idle_err_s || hdr_err_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign req_ready     = req_ready_s;
    assign out_valid     = out_valid_r;
    assign out_flit      = out_flit_r;
    assign out_is_header = out_hdr_r;
    assign out_is_tail   = out_tail_r;
    assign grant_id      = grant_r;
    assign busy          = (state_r == ST_LOCKED);
    assign pkt_count     = pkt_count_r;
    assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter: per-source flit queues drive the inputs,
// expected output flits are queued in hand-computed order and checked by a monitor.
module tb_noc_inject_arbiter;

    typedef logic [33:0] ent_t;   // {tail, header, flit}

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_flit;
    logic [3:0]   req_is_header;
    logic [3:0]   req_is_tail;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_flit;
    logic         out_is_header;
    logic         out_is_tail;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  pkt_count;
    logic         proto_err;

    ent_t         src_q [4][$];
    ent_t         exp_q [$];
    logic [3:0]   fire;
    int           n_cmp = 0;
    int           n_err = 0;

    noc_inject_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .noc_clk(clk), .noc_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
        .req_is_header(req_is_header), .req_is_tail(req_is_tail),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .out_is_header(out_is_header), .out_is_tail(out_is_tail),
        .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_src(input int src, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++)
            src_q[src].push_back({(k == n - 1), (k == 0), base + 32'(k)});
    endtask

    task automatic add_exp(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++)
            exp_q.push_back({(k == n - 1), (k == 0), base + 32'(k)});
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_out_flit"},  out_flit, 32'h0);
        check({tag, "_grant_id"},  32'(grant_id), 32'h0);
        check({tag, "_busy"},      32'(busy), 32'h0);
        check({tag, "_pkt_count"}, 32'(pkt_count), 32'h0);
        check({tag, "_proto_err"}, 32'(proto_err), 32'h0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    endtask

    task automatic wait_drain(input int bound);
        int  c;
        bit  done;
        c = 0;
        done = 1'b0;
        while (!done && c < bound) begin
            tick();
            c++;
            done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
                   (src_q[3].size() == 0) && (exp_q.size() == 0) && !out_valid && !busy;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", exp_q.size());
        end
    endtask

    // Source driver: retire accepted flits, present the head of each source queue.
    initial begin
        ent_t e;
        req_valid = 4'h0;
        req_flit = 128'h0;
        req_is_header = 4'h0;
        req_is_tail = 4'h0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    e = src_q[i][0];
                    req_valid[i] = 1'b1;
                    req_flit[i*32 +: 32] = e[31:0];
                    req_is_header[i] = e[32];
                    req_is_tail[i] = e[33];
                end else begin
                    req_valid[i] = 1'b0;
                    req_flit[i*32 +: 32] = 32'h0;
                    req_is_header[i] = 1'b0;
                    req_is_tail[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: sample handshakes mid-cycle and compare delivered flits with the scoreboard.
    initial begin
        ent_t exp_e;
        fire = 4'h0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_unexpected: got %0h expected none",
                             {out_is_tail, out_is_header, out_flit});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({out_is_tail, out_is_header, out_flit} !== exp_e) begin
                        n_err++;
                        $display("FAIL scoreboard: got %0h expected %0h",
                                 {out_is_tail, out_is_header, out_flit}, exp_e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check_reset_vals("por");
        rst = 1'b0;

        // Reset in the middle of a packet from req2 drops it.
        add_src(2, 4, 32'h2000_0000);
        add_exp(4, 32'h2000_0000);
        repeat (4) tick();
        check("busy_mid_pkt", 32'(busy), 32'h1);
        rst = 1'b1;
        clear_all();
        tick();
        check_reset_vals("mid_rst");
        tick();
        rst = 1'b0;
        add_src(3, 1, 32'h3100_0000);
        add_src(0, 1, 32'h0100_0000);
        add_exp(1, 32'h0100_0000);
        add_exp(1, 32'h3100_0000);
        wait_drain(50);
        check("rst_pkt_count", 32'(pkt_count), 32'd2);
        check("rst_grant", 32'(grant_id), 32'd3);

        // Four simultaneous headers, then 3 and 0 together.
        for (int i = 0; i < 4; i++) add_src(i, 2, 32'h0300_0000 + 32'(i) * 32'h1000_0000);
        for (int i = 0; i < 4; i++) add_exp(2, 32'h0300_0000 + 32'(i) * 32'h1000_0000);
        wait_drain(100);
        check("cont_pkt_count", 32'(pkt_count), 32'd6);
        check("cont_grant", 32'(grant_id), 32'd3);
        add_src(3, 2, 32'h3400_0000);
        add_src(0, 2, 32'h0400_0000);
        add_exp(2, 32'h0400_0000);
        add_exp(2, 32'h3400_0000);
        wait_drain(50);
        check("cont2_pkt_count", 32'(pkt_count), 32'd8);
        check("cont_proto_err", 32'(proto_err), 32'h0);

        // Single 4-flit packet from req1: output valid in cycles 2..5.
        add_src(1, 4, 32'h1200_0000);
        add_exp(4, 32'h1200_0000);
        tick();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("lat_out_valid_c%0d", k), 32'(out_valid), (k >= 2 && k <= 5) ? 32'h1 : 32'h0);
            if (k == 1) check("lat_busy_c1", 32'(busy), 32'h1);
            tick();
        end
        wait_drain(20);
        check("single_pkt_count", 32'(pkt_count), 32'd9);
        check("single_grant", 32'(grant_id), 32'd1);

        // Body flit without header on req2 while idle.
        src_q[2].push_back({1'b0, 1'b0, 32'h2500_0000});
        tick();
        tick();
        check("err_proto_set", 32'(proto_err), 32'h1);
        check("err_no_busy", 32'(busy), 32'h0);
        check("err_no_grant", 32'(grant_id), 32'd1);
        check("err_req_ready", 32'(req_ready), 32'h0);
        src_q[2].delete();
        repeat (3) tick();
        check("err_proto_sticky", 32'(proto_err), 32'h1);
        check("err_grant_after", 32'(grant_id), 32'd1);

        // Backpressure: stall with the header sitting in the slice.
        add_src(2, 6, 32'h2600_0000);
        add_exp(6, 32'h2600_0000);
        repeat (3) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_flit", out_flit, 32'h2600_0000);
            check("bp_out_valid", 32'(out_valid), 32'h1);
            check("bp_req_ready", 32'(req_ready[2]), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        wait_drain(50);
        check("bp_pkt_count", 32'(pkt_count), 32'd10);

        // Counter wrap.
        force dut.pkt_count_r = 16'hFFFF;
        tick();
        release dut.pkt_count_r;
        tick();
        check("wrap_preload", 32'(pkt_count), 32'h0000_FFFF);
        add_src(0, 1, 32'h0600_0000);
        add_exp(1, 32'h0600_0000);
        wait_drain(20);
        check("wrap_pkt_count", 32'(pkt_count), 32'h0);

        check("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
